palette_video_out: RTL and testbench
====================================

Name: palette_video_out

Overview:
- Parametrised, runtime-loadable palette stage that maps the video core's colour index to RGB.
- Sits between the machine glue (pixel, color, syncs, blanks) and video_mixer.
- Replaces the fixed 16-entry constant palette.
- Adds multiple palette banks, blank masking, pipelined sync alignment, and palette loading from the HPS download stream.

Parameters:
- IDX_W, 4, colour index width; entries per bank = 2^IDX_W.
- COMP_W, 6, stored bits per R/G/B component.
- OUT_W, 8, output bits per component; OUT_W >= COMP_W.
- BANKS, 2, number of palette banks; power of two, >= 1.
- DN_INDEX, 8'd2, ioctl_index value that selects palette download.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce_pix  in  1  pixel clock enable.
- pixel  in  1  pixel on (1) / background off (0).
- color  in  IDX_W  colour index.
- bank_sel  in  max(1,clog2(BANKS))  active palette bank.
- hsync_in, vsync_in, hblank_in, vblank_in  in  1 each  raw video timing.
- dn_go  in  1  download active.
- dn_index  in  8  download target index.
- dn_wr  in  1  download byte strobe.
- dn_data  in  8  download byte.
- r, g, b  out  OUT_W each  pixel colour.
- hsync, vsync, hblank, vblank  out  1 each  timing aligned to r/g/b.
- ce_out  out  1  ce_pix delayed one clk_sys.
- busy  out  1  palette load in progress.
- load_done  out  1  one-cycle pulse at the end of a load.
- overflow  out  1  sticky: bytes arrived beyond the last entry.

Behaviour:
- Reset: all outputs 0; loader in IDLE; phase and entry counters 0; overflow cleared.
- Palette RAM is not cleared by reset.
- Power-up RAM contents: every bank holds a grey ramp. Each component = index MSB-replicated to COMP_W (IDX_W=4, COMP_W=6 gives {idx, idx[3:2]}).
- Pipeline advances only on clk_sys cycles with ce_pix=1.
  - Stage 1 registers color, bank_sel, pixel, the four timing inputs, and blank = hblank_in|vblank_in.
  - Stage 2 registers the RAM read and the delayed timing signals.
  - Latency is exactly 2 ce_pix strobes.
  - Outputs hold their value between strobes.
- Colour rule: if stage-1 pixel=0 or blank=1, r=g=b=0. Otherwise each component = the stored COMP_W value MSB-replicated to OUT_W (6→8: {c, c[5:4]}).
- RAM address = {bank_sel, color}. When BANKS=1, bank_sel is ignored.
- ce_out = ce_pix registered once.
- Loader FSM states: IDLE, LOAD.
  - IDLE→LOAD on a rising edge of dn_go while dn_index==DN_INDEX. On entry: phase=0, entry=0, overflow=0, busy=1.
  - In LOAD, each dn_wr advances phase 0→1→2→0. Phase 0 latches R, phase 1 latches G; each takes dn_data[7:8-COMP_W].
  - Phase 2 commits {R,G,B} to RAM[entry] on that cycle, then entry increments.
  - Entry order: bank 0 entries 0..2^IDX_W-1, then bank 1, and so on, up to BANKS*2^IDX_W entries.
  - After the last entry commits, further dn_wr writes nothing and sets overflow=1.
  - LOAD→IDLE when dn_go falls: busy=0, load_done pulses for 1 cycle, and a partial triplet is discarded.
- dn_wr in IDLE, or while dn_index != DN_INDEX, is ignored.
- A dn_wr on the same cycle as dn_go's rising edge is ignored; the first byte is taken the following cycle or later.
- Read/write collision (same entry, same cycle): the read returns the old value; the new value is visible on the next read.
- Loads may run while video is active; entries update as committed.
- Reset during LOAD: return to IDLE, busy=0, no load_done pulse; entries already committed are kept.
- bank_sel changes take effect on the next ce_pix strobe via stage 1; no glitches between strobes.

Test Plan:
- Reset released; ce_pix every 4th clk; color=4'd15, pixel=1, no blanks. After 2 strobes r=g=b=8'hFF; after color=0, r=g=b=8'h00.
- Download with dn_index=2: bytes FF,00,00 then 00,FF,00 (entries 0,1). busy=1 during, load_done single pulse at the fall. color=1 gives r=00 g=FF b=00; color=0 gives r=FF g=00 b=00.
- Load 33 triplets (BANKS=2): entry 16 lands in bank 1. bank_sel=1, color=0 gives the 17th triplet. The 33rd triplet sets overflow=1, and RAM[31] is unchanged by it.
- Blanking: hblank_in=1 with pixel=1, color=15 gives r=g=b=0 and hblank=1, both exactly 2 strobes later. Verify hsync/vsync alignment with an edge test.
- Reset mid-load after 4 bytes: busy→0, no load_done pulse. Entry 0 keeps the committed value; entry 1 keeps its prior value.
- dn_index=1 download: no RAM change, busy stays 0.

Source files
------------

// File: rtl/palette_video_out.sv
// rtl/palette_video_out.sv - banked, runtime-loadable colour palette with blank masking and sync alignment
module palette_video_out #(
  parameter int          IDX_W    = 4,
  parameter int          COMP_W   = 6,
  parameter int          OUT_W    = 8,
  parameter int          BANKS    = 2,
  parameter logic [7:0]  DN_INDEX = 8'd2,
  localparam int         BSEL_W   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              pixel,
  input  logic [IDX_W-1:0]  color,
  input  logic [BSEL_W-1:0] bank_sel,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblank_in,
  input  logic              vblank_in,
  input  logic              dn_go,
  input  logic [7:0]        dn_index,
  input  logic              dn_wr,
  input  logic [7:0]        dn_data,
  output logic [OUT_W-1:0]  r,
  output logic [OUT_W-1:0]  g,
  output logic [OUT_W-1:0]  b,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              ce_out,
  output logic              busy,
  output logic              load_done,
  output logic              overflow
);

  localparam int ENTRIES = BANKS << IDX_W;
  localparam int AW      = (BANKS > 1) ? IDX_W + $clog2(BANKS) : IDX_W;
  localparam int RGB_W   = 3 * COMP_W;
  localparam logic [AW:0] FULL = (AW + 1)'(ENTRIES);

  typedef logic [ENTRIES-1:0][RGB_W-1:0] ram_t;
  typedef enum logic {IDLE, LOAD} state_t;

  // Power-up image: every bank is a grey ramp of its own index.
  function automatic ram_t grey_ramp();
    ram_t              img;
    logic [IDX_W-1:0]  idx;
    logic [COMP_W-1:0] c;
    for (int e = 0; e < ENTRIES; e++) begin
      idx = IDX_W'(e);
      for (int k = 0; k < COMP_W; k++) c[COMP_W-1-k] = idx[IDX_W-1-(k % IDX_W)];
      img[e] = {c, c, c};
    end
    return img;
  endfunction

  function automatic logic [OUT_W-1:0] widen(input logic [COMP_W-1:0] c);
    logic [OUT_W-1:0] w;
    for (int k = 0; k < OUT_W; k++) w[OUT_W-1-k] = c[COMP_W-1-(k % COMP_W)];
    return w;
  endfunction

  ram_t ram = grey_ramp();

  logic [AW-1:0]     rd_addr, s1_addr;
  logic              s1_pixel, s1_blank, s1_hs, s1_vs, s1_hb, s1_vb;
  logic [RGB_W-1:0]  rd_word;
  logic              unused_bits;

  assign rd_addr     = AW'({bank_sel, color});
  assign rd_word     = ram[s1_addr];
  assign unused_bits = ^{dn_data, bank_sel};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_addr  <= '0;
      s1_pixel <= 1'b0;
      s1_blank <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_hb    <= 1'b0;
      s1_vb    <= 1'b0;
      r        <= '0;
      g        <= '0;
      b        <= '0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      hblank   <= 1'b0;
      vblank   <= 1'b0;
      ce_out   <= 1'b0;
    end else begin
      ce_out <= ce_pix;
      if (ce_pix) begin
        s1_addr  <= rd_addr;
        s1_pixel <= pixel;
        s1_blank <= hblank_in | vblank_in;
        s1_hs    <= hsync_in;
        s1_vs    <= vsync_in;
        s1_hb    <= hblank_in;
        s1_vb    <= vblank_in;
        hsync    <= s1_hs;
        vsync    <= s1_vs;
        hblank   <= s1_hb;
        vblank   <= s1_vb;
        if (s1_pixel && !s1_blank) begin
          r <= widen(rd_word[RGB_W-1 -: COMP_W]);
          g <= widen(rd_word[2*COMP_W-1 -: COMP_W]);
          b <= widen(rd_word[COMP_W-1:0]);
        end else begin
          r <= '0;
          g <= '0;
          b <= '0;
        end
      end
    end
  end

  state_t             state, state_n;
  logic [1:0]         phase, phase_n;
  logic [AW:0]        entry, entry_n;
  logic [COMP_W-1:0]  r_lat, g_lat, r_lat_n, g_lat_n;
  logic               dn_go_d, overflow_n, done_n, we, sel;
  logic [COMP_W-1:0]  dn_comp;

  assign sel     = (dn_index == DN_INDEX);
  assign dn_comp = dn_data[7 -: COMP_W];
  assign busy    = (state == LOAD);

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    entry_n    = entry;
    r_lat_n    = r_lat;
    g_lat_n    = g_lat;
    overflow_n = overflow;
    done_n     = 1'b0;
    we         = 1'b0;
    case (state)
      IDLE: begin
        if (dn_go && !dn_go_d && sel) begin
          state_n    = LOAD;
          phase_n    = 2'd0;
          entry_n    = '0;
          overflow_n = 1'b0;
        end
      end
      LOAD: begin
        // Falling dn_go drops any partial triplet simply by resetting phase.
        if (!dn_go) begin
          state_n = IDLE;
          phase_n = 2'd0;
          done_n  = 1'b1;
        end else if (dn_wr && sel) begin
          if (entry == FULL) begin
            overflow_n = 1'b1;
          end else begin
            case (phase)
              2'd0: begin
                r_lat_n = dn_comp;
                phase_n = 2'd1;
              end
              2'd1: begin
                g_lat_n = dn_comp;
                phase_n = 2'd2;
              end
              default: begin
                we      = 1'b1;
                phase_n = 2'd0;
                entry_n = entry + 1'b1;
              end
            endcase
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 2'd0;
      entry     <= '0;
      r_lat     <= '0;
      g_lat     <= '0;
      overflow  <= 1'b0;
      load_done <= 1'b0;
      dn_go_d   <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      entry     <= entry_n;
      r_lat     <= r_lat_n;
      g_lat     <= g_lat_n;
      overflow  <= overflow_n;
      load_done <= done_n;
      dn_go_d   <= dn_go;
    end
  end

  // Palette storage keeps its contents across reset; a same-cycle read sees the old word.
  always_ff @(posedge clk_sys) begin
    if (we) ram[entry[AW-1:0]] <= {r_lat, g_lat, dn_comp};
  end

endmodule

// File: tb/tb_palette_video_out.sv
// tb/tb_palette_video_out.sv - table, directed and randomized checks of palette_video_out
module tb_palette_video_out;

  logic       clk_sys = 1'b0, reset = 1'b1, ce_pix = 1'b0, pixel = 1'b0;
  logic [3:0] color = '0;
  logic [0:0] bank_sel = '0;
  logic       hsync_in = 0, vsync_in = 0, hblank_in = 0, vblank_in = 0;
  logic       dn_go = 0, dn_wr = 0;
  logic [7:0] dn_index = '0, dn_data = '0;
  logic [7:0] r, g, b;
  logic       hsync, vsync, hblank, vblank, ce_out, busy, load_done, overflow;

  palette_video_out dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .pixel(pixel), .color(color),
    .bank_sel(bank_sel), .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in),
    .vblank_in(vblank_in), .dn_go(dn_go), .dn_index(dn_index), .dn_wr(dn_wr), .dn_data(dn_data),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .ce_out(ce_out), .busy(busy), .load_done(load_done), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [3:0] color;
    logic       pixel;
    logic       bank;
    logic       hs, vs, hb, vb;
  } vin_t;

  typedef struct {
    vin_t        in;
    logic [23:0] exp_rgb;
    logic        exp_hb;
  } tv_t;

  int checks = 0, errors = 0;
  logic [5:0] mr[32], mg[32], mb[32];
  logic [7:0] dq[$];
  int         dl_idx;
  vin_t       prev = '0;
  logic [7:0] tb_bytes[99];
  tv_t        tbl[7];
  int         pulses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] wid(input logic [5:0] c);
    logic [7:0] x;
    x = {2'b00, c};
    return (x << 2) | (x >> 4);
  endfunction

  // One pixel strobe; outputs must reflect the inputs of the previous strobe.
  task automatic vid(input vin_t v);
    logic [4:0] a;
    logic [23:0] e;
    @(negedge clk_sys);
    color = v.color; pixel = v.pixel; bank_sel = v.bank;
    hsync_in = v.hs; vsync_in = v.vs; hblank_in = v.hb; vblank_in = v.vb;
    ce_pix = 1'b1;
    @(negedge clk_sys);
    ce_pix = 1'b0;
    chk("ce_out_high", {31'b0, ce_out}, 1);
    repeat (3) @(negedge clk_sys);
    a = {prev.bank, prev.color};
    e = (prev.pixel && !prev.hb && !prev.vb) ? {wid(mr[a]), wid(mg[a]), wid(mb[a])} : 24'h0;
    chk("model_rgb", {8'h0, r, g, b}, {8'h0, e});
    chk("model_timing", {28'h0, hsync, vsync, hblank, vblank}, {28'h0, prev.hs, prev.vs, prev.hb, prev.vb});
    chk("ce_out_low", {31'b0, ce_out}, 0);
    prev = v;
  endtask

  function automatic vin_t mk(input int c, input int p, input int bk, input int hs, input int vs,
                              input int hb, input int vb);
    vin_t v;
    v.color = 4'(c); v.pixel = 1'(p); v.bank = 1'(bk);
    v.hs = 1'(hs); v.vs = 1'(vs); v.hb = 1'(hb); v.vb = 1'(vb);
    return v;
  endfunction

  task automatic commit_model();
    int n;
    if (dl_idx == 2) begin
      n = dq.size() / 3;
      if (n > 32) n = 32;
      for (int k = 0; k < n; k++) begin
        mr[k] = dq[3*k][7:2];
        mg[k] = dq[3*k+1][7:2];
        mb[k] = dq[3*k+2][7:2];
      end
    end
  endtask

  task automatic dl_go(input logic [7:0] idx);
    @(negedge clk_sys);
    dq.delete();
    dl_idx = idx;
    dn_index = idx; dn_go = 1'b1; dn_wr = 1'b1; dn_data = 8'h5A;
    @(negedge clk_sys);
    dn_wr = 1'b0;
  endtask

  task automatic dl_byte(input logic [7:0] bt);
    dn_data = bt; dn_wr = 1'b1;
    @(negedge clk_sys);
    dn_wr = 1'b0;
    @(negedge clk_sys);
    if (dl_idx == 2) dq.push_back(bt);
  endtask

  task automatic dl_end(output int np);
    dn_go = 1'b0;
    np = 0;
    repeat (4) begin
      @(negedge clk_sys);
      if (load_done) np++;
    end
    commit_model();
  endtask

  task automatic check_entry(input string name, input int bk, input int c, input logic [23:0] exp);
    vid(mk(c, 1, bk, 0, 0, 0, 0));
    vid(mk(c, 1, bk, 0, 0, 0, 0));
    chk(name, {8'h0, r, g, b}, {8'h0, exp});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mr[i] = 6'(((i % 16) << 2) | ((i % 16) >> 2));
      mg[i] = mr[i];
      mb[i] = mr[i];
    end
    tbl[0] = '{mk(15, 1, 0, 0, 0, 0, 0), 24'hFFFFFF, 1'b0};
    tbl[1] = '{mk(0,  1, 0, 0, 0, 0, 0), 24'h000000, 1'b0};
    tbl[2] = '{mk(8,  1, 0, 0, 0, 0, 0), 24'h8A8A8A, 1'b0};
    tbl[3] = '{mk(5,  1, 1, 0, 0, 0, 0), 24'h555555, 1'b0};
    tbl[4] = '{mk(10, 0, 0, 0, 0, 0, 0), 24'h000000, 1'b0};
    tbl[5] = '{mk(15, 1, 0, 0, 0, 1, 0), 24'h000000, 1'b1};
    tbl[6] = '{mk(12, 1, 1, 0, 0, 0, 1), 24'h000000, 1'b0};

    repeat (3) @(negedge clk_sys);
    chk("reset_rgb", {8'h0, r, g, b}, 0);
    chk("reset_flags", {23'h0, hsync, vsync, hblank, vblank, ce_out, busy, load_done, overflow}, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      vid(tbl[i].in);
      vid(tbl[i].in);
      chk("table_rgb", {8'h0, r, g, b}, {8'h0, tbl[i].exp_rgb});
      chk("table_hblank", {31'b0, hblank}, {31'b0, tbl[i].exp_hb});
    end

    vid(mk(0, 0, 0, 1, 0, 0, 0));
    chk("hsync_edge_lat1", {31'b0, hsync}, 0);
    vid(mk(0, 0, 0, 1, 1, 0, 0));
    chk("hsync_edge_lat2", {30'b0, hsync, vsync}, 2'b10);
    vid(mk(0, 0, 0, 0, 1, 0, 0));
    chk("vsync_edge_lat2", {30'b0, hsync, vsync}, 2'b11);
    vid(mk(0, 0, 0, 0, 0, 0, 0));
    chk("hsync_fall", {30'b0, hsync, vsync}, 2'b01);

    dl_go(8'd2);
    chk("busy_start", {31'b0, busy}, 1);
    dl_byte(8'hFF); dl_byte(8'h00); dl_byte(8'h00);
    dl_byte(8'h00); dl_byte(8'hFF); dl_byte(8'h00);
    chk("busy_during", {31'b0, busy}, 1);
    dl_end(pulses);
    chk("load_done_pulses", pulses, 1);
    chk("busy_after", {31'b0, busy}, 0);
    chk("overflow_small", {31'b0, overflow}, 0);
    check_entry("entry1_green", 0, 1, 24'h00FF00);
    check_entry("entry0_red", 0, 0, 24'hFF0000);

    for (int i = 0; i < 96; i++) tb_bytes[i] = 8'($urandom);
    for (int i = 96; i < 99; i++) tb_bytes[i] = ~tb_bytes[i - 3];
    dl_go(8'd2);
    for (int i = 0; i < 99; i++) begin
      if (i == 96) chk("overflow_at_full", {31'b0, overflow}, 0);
      dl_byte(tb_bytes[i]);
    end
    chk("overflow_set", {31'b0, overflow}, 1);
    dl_end(pulses);
    chk("load_done_33", pulses, 1);
    chk("overflow_sticky", {31'b0, overflow}, 1);
    check_entry("bank1_entry0", 1, 0, {wid(tb_bytes[48][7:2]), wid(tb_bytes[49][7:2]), wid(tb_bytes[50][7:2])});
    check_entry("bank1_entry15", 1, 15, {wid(tb_bytes[93][7:2]), wid(tb_bytes[94][7:2]), wid(tb_bytes[95][7:2])});
    check_entry("bank0_entry15", 0, 15, {wid(tb_bytes[45][7:2]), wid(tb_bytes[46][7:2]), wid(tb_bytes[47][7:2])});

    dl_go(8'd2);
    dl_byte(8'h12); dl_byte(8'h34); dl_byte(8'h56); dl_byte(8'h78);
    @(negedge clk_sys);
    reset = 1'b1; dn_go = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk_sys);
      if (load_done) pulses++;
    end
    chk("busy_in_reset", {31'b0, busy}, 0);
    reset = 1'b0;
    prev = '0;
    repeat (3) begin
      @(negedge clk_sys);
      if (load_done) pulses++;
    end
    chk("no_done_on_reset", pulses, 0);
    commit_model();
    check_entry("reset_entry0_kept", 0, 0, {wid(6'h04), wid(6'h0D), wid(6'h15)});
    check_entry("reset_entry1_old", 0, 1, {wid(tb_bytes[3][7:2]), wid(tb_bytes[4][7:2]), wid(tb_bytes[5][7:2])});

    dl_go(8'd1);
    chk("other_index_idle", {31'b0, busy}, 0);
    for (int i = 0; i < 6; i++) dl_byte(8'hC3);
    chk("other_index_busy", {31'b0, busy}, 0);
    dl_end(pulses);
    chk("other_index_done", pulses, 0);

    for (int i = 0; i < 60; i++) begin
      vid(mk($urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
